// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode constants and sequencer state encoding shared with decode
package isa_pkg;

    localparam int OP_W = 5;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LDM   = 5'b10001;
    localparam logic [4:0] OP_CALL  = 5'b11000;
    localparam logic [4:0] OP_CALL2 = 5'b11001;
    localparam logic [4:0] OP_RET   = 5'b11010;
    localparam logic [4:0] OP_RET2  = 5'b11011;
    localparam logic [4:0] OP_RTI   = 5'b11100;
    localparam logic [4:0] OP_RTI2  = 5'b11101;
    localparam logic [4:0] OP_INT1  = 5'b11110;
    localparam logic [4:0] OP_INT2  = 5'b11111;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CALL2,
        SEQ_RET2,
        SEQ_RTI2,
        SEQ_INT1,
        SEQ_INT2,
        SEQ_IMM
    } seqState_e;

    // State entered after an opcode is consumed in IDLE.
    function automatic seqState_e followState(input logic [4:0] op);
        case (op)
            OP_CALL: return SEQ_CALL2;
            OP_RET:  return SEQ_RET2;
            OP_RTI:  return SEQ_RTI2;
            OP_LDM:  return SEQ_IMM;
            default: return SEQ_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/opcode_sequencer_if.sv
// rtl/opcode_sequencer_if.sv - fetch/decode side signals of the IF/ID opcode stage
interface opcode_sequencer_if #(
    parameter int OPW = isa_pkg::OP_W
);

    logic [OPW-1:0] fetchOpCode;
    logic           fetchValid;
    logic           stall;
    logic           flush;
    logic           intrReq;
    logic [OPW-1:0] opCode;
    logic           makeMeBubble;
    logic           immSlot;
    logic           intrAck;
    logic           fetchHold;
    logic           busy;

    modport master (
        input  fetchOpCode, fetchValid, stall, flush, intrReq,
        output opCode, makeMeBubble, immSlot, intrAck, fetchHold, busy
    );

    modport slave (
        output fetchOpCode, fetchValid, stall, flush, intrReq,
        input  opCode, makeMeBubble, immSlot, intrAck, fetchHold, busy
    );

endinterface

// File: rtl/opcode_sequencer_intr_sync_edge.sv
// rtl/opcode_sequencer_intr_sync_edge.sv - interrupt request synchroniser with rising-edge pulse
module intr_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic risePulse
);

    logic [STAGES-1:0] syncQ;
    logic              lastQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ <= '0;
            lastQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[STAGES-2:0], asyncIn};
            lastQ <= syncQ[STAGES-1];
        end
    end

    assign risePulse = syncQ[STAGES-1] & ~lastQ;

endmodule

// File: rtl/opcode_sequencer.sv
// rtl/opcode_sequencer.sv - IF/ID opcode stage: expands two-part ops, injects interrupts, bubbles
module opcode_sequencer #(
    parameter int OPW       = isa_pkg::OP_W,
    parameter int INTR_SYNC = 2
) (
    input logic                clk,
    input logic                rst,
    opcode_sequencer_if.master bus
);

    import isa_pkg::*;

    seqState_e      state;
    logic           pending;
    logic           intrRise;
    logic [OPW-1:0] opCodeQ;
    logic           bubbleQ;
    logic           immQ;
    logic           ackQ;
    logic           holdComb;

    intr_sync_edge #(
        .STAGES(INTR_SYNC)
    ) u_intrSync (
        .clk      (clk),
        .rst      (rst),
        .asyncIn  (bus.intrReq),
        .risePulse(intrRise)
    );

    // fetchHold mirrors the decision the FSM takes at the coming edge.
    always_comb begin
        holdComb = 1'b0;
        if (rst || bus.stall) begin
            holdComb = 1'b1;
        end else if (bus.flush && (state == SEQ_IDLE || state == SEQ_IMM)) begin
            holdComb = 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: holdComb = pending;
                SEQ_IMM:  holdComb = 1'b0;
                default:  holdComb = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SEQ_IDLE;
            pending <= 1'b0;
            opCodeQ <= OP_NOP;
            bubbleQ <= 1'b0;
            immQ    <= 1'b0;
            ackQ    <= 1'b0;
        end else begin
            opCodeQ <= OP_NOP;
            bubbleQ <= 1'b0;
            immQ    <= 1'b0;
            ackQ    <= 1'b0;
            // A stalled sequencer still latches a new request edge; it only defers issuing it.
            pending <= pending | intrRise;
            if (bus.stall) begin
                bubbleQ <= 1'b1;
            end else if (bus.flush && (state == SEQ_IDLE || state == SEQ_IMM)) begin
                state <= SEQ_IDLE;
            end else begin
                case (state)
                    SEQ_CALL2: begin
                        opCodeQ <= OP_CALL2;
                        state   <= SEQ_IDLE;
                    end
                    SEQ_RET2: begin
                        opCodeQ <= OP_RET2;
                        state   <= SEQ_IDLE;
                    end
                    SEQ_RTI2: begin
                        opCodeQ <= OP_RTI2;
                        state   <= SEQ_IDLE;
                    end
                    SEQ_INT1: begin
                        opCodeQ <= OP_INT2;
                        ackQ    <= 1'b1;
                        pending <= 1'b0;
                        state   <= SEQ_INT2;
                    end
                    SEQ_INT2: begin
                        state <= SEQ_IDLE;
                    end
                    SEQ_IMM: begin
                        immQ  <= 1'b1;
                        state <= SEQ_IDLE;
                    end
                    default: begin
                        if (pending) begin
                            opCodeQ <= OP_INT1;
                            state   <= SEQ_INT1;
                        end else if (bus.fetchValid) begin
                            opCodeQ <= bus.fetchOpCode;
                            state   <= followState(bus.fetchOpCode);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.opCode       = opCodeQ;
    assign bus.makeMeBubble = bubbleQ;
    assign bus.immSlot      = immQ;
    assign bus.intrAck      = ackQ;
    assign bus.fetchHold    = holdComb;
    assign bus.busy         = (state != SEQ_IDLE);

endmodule

// File: tb/tb_opcode_sequencer.sv
// tb/tb_opcode_sequencer.sv - vector table, reset corner and randomized reference-model bench
module tb_opcode_sequencer;

    localparam int SYNC = 2;

    logic clk;
    logic rst;
    int   nVec;
    int   nMis;

    opcode_sequencer_if bus ();

    opcode_sequencer #(
        .OPW      (5),
        .INTR_SYNC(SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        bit         v, st, fl, ir;
        bit         eHold, eBusy;
        logic [4:0] eOp;
        bit         eBub, eImm, eAck;
    } vec_t;

    typedef struct packed {
        logic [4:0] op;
        logic       imm;
        logic       ack;
    } owed_t;

    vec_t  vecs[$];
    owed_t owed[$];   // slots the sequencer still owes decode before it may take a new word
    bit    mPending;
    bit    hist[$];   // sampled intrReq, newest first

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mReset();
        owed.delete();
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
        mPending = 1'b0;
    endtask

    function automatic bit mHold(input bit st, input bit fl);
        if (st) return 1'b1;
        if (owed.size() == 0) return fl ? 1'b0 : mPending;
        return owed[0].imm ? 1'b0 : 1'b1;
    endfunction

    task automatic mStep(input logic [4:0] op, input bit v, input bit st, input bit fl, input bit ir,
                         output logic [4:0] eOp, output bit eBub, output bit eImm, output bit eAck);
        bit    rise;
        bit    clr;
        owed_t o;
        rise = hist[SYNC-1] & !hist[SYNC];
        clr  = 1'b0;
        eOp  = 5'b0;
        eBub = 1'b0;
        eImm = 1'b0;
        eAck = 1'b0;
        if (st) begin
            eBub = 1'b1;
        end else if (fl && (owed.size() == 0 || owed[0].imm)) begin
            owed.delete();
        end else if (owed.size() != 0) begin
            o    = owed.pop_front();
            eOp  = o.op;
            eImm = o.imm;
            eAck = o.ack;
            clr  = o.ack;
        end else if (mPending) begin
            eOp = 5'b11110;
            owed.push_back('{op: 5'b11111, imm: 1'b0, ack: 1'b1});
            owed.push_back('{op: 5'b00000, imm: 1'b0, ack: 1'b0});
        end else if (v) begin
            eOp = op;
            case (op)
                5'b11000: owed.push_back('{op: 5'b11001, imm: 1'b0, ack: 1'b0});
                5'b11010: owed.push_back('{op: 5'b11011, imm: 1'b0, ack: 1'b0});
                5'b11100: owed.push_back('{op: 5'b11101, imm: 1'b0, ack: 1'b0});
                5'b10001: owed.push_back('{op: 5'b00000, imm: 1'b1, ack: 1'b0});
                default: ;
            endcase
        end
        mPending = clr ? 1'b0 : (mPending | rise);
        hist.push_front(ir);
        void'(hist.pop_back());
    endtask

    task automatic runCycle(input vec_t x, input string tag);
        @(negedge clk);
        bus.fetchOpCode = x.op;
        bus.fetchValid  = x.v;
        bus.stall       = x.st;
        bus.flush       = x.fl;
        bus.intrReq     = x.ir;
        #1;
        check({tag, ".fetchHold"}, 32'(bus.fetchHold), 32'(x.eHold));
        check({tag, ".busy"}, 32'(bus.busy), 32'(x.eBusy));
        @(posedge clk);
        #1;
        check({tag, ".opCode"}, 32'(bus.opCode), 32'(x.eOp));
        check({tag, ".makeMeBubble"}, 32'(bus.makeMeBubble), 32'(x.eBub));
        check({tag, ".immSlot"}, 32'(bus.immSlot), 32'(x.eImm));
        check({tag, ".intrAck"}, 32'(bus.intrAck), 32'(x.eAck));
    endtask

    initial begin
        vec_t  r;
        bit    irLevel;
        logic [4:0] pick [8];

        nVec = 0;
        nMis = 0;
        rst             = 1'b1;
        bus.fetchOpCode = 5'b0;
        bus.fetchValid  = 1'b0;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.intrReq     = 1'b0;
        #3;
        check("reset.opCode", 32'(bus.opCode), 32'h0);
        check("reset.makeMeBubble", 32'(bus.makeMeBubble), 32'h0);
        check("reset.immSlot", 32'(bus.immSlot), 32'h0);
        check("reset.intrAck", 32'(bus.intrAck), 32'h0);
        check("reset.fetchHold", 32'(bus.fetchHold), 32'h1);
        check("reset.busy", 32'(bus.busy), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mReset();

        // op, v, st, fl, ir, eHold, eBusy, eOp, eBub, eImm, eAck
        vecs.push_back('{5'b11000, 1, 0, 0, 0, 0, 0, 5'b11000, 0, 0, 0});
        vecs.push_back('{5'b01001, 1, 0, 0, 0, 1, 1, 5'b11001, 0, 0, 0});
        vecs.push_back('{5'b01001, 1, 0, 0, 0, 0, 0, 5'b01001, 0, 0, 0});
        vecs.push_back('{5'b10001, 1, 0, 0, 0, 0, 0, 5'b10001, 0, 0, 0});
        vecs.push_back('{5'b11111, 1, 0, 0, 0, 0, 1, 5'b00000, 0, 1, 0});
        vecs.push_back('{5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b11100, 1, 0, 0, 0, 0, 0, 5'b11100, 0, 0, 0});
        vecs.push_back('{5'b00011, 1, 1, 0, 0, 1, 1, 5'b00000, 1, 0, 0});
        vecs.push_back('{5'b00011, 1, 1, 0, 0, 1, 1, 5'b00000, 1, 0, 0});
        vecs.push_back('{5'b00011, 1, 1, 0, 0, 1, 1, 5'b00000, 1, 0, 0});
        vecs.push_back('{5'b00011, 1, 0, 1, 0, 1, 1, 5'b11101, 0, 0, 0});
        vecs.push_back('{5'b00011, 1, 0, 0, 0, 0, 0, 5'b00011, 0, 0, 0});
        vecs.push_back('{5'b01010, 1, 0, 1, 0, 0, 0, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b10001, 1, 0, 0, 0, 0, 0, 5'b10001, 0, 0, 0});
        vecs.push_back('{5'b00111, 1, 0, 1, 0, 0, 1, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0});
        // interrupt behind a RET pair
        vecs.push_back('{5'b00000, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b11010, 1, 0, 0, 1, 0, 0, 5'b11010, 0, 0, 0});
        vecs.push_back('{5'b00110, 1, 0, 0, 1, 1, 1, 5'b11011, 0, 0, 0});
        vecs.push_back('{5'b00110, 1, 0, 0, 1, 1, 0, 5'b11110, 0, 0, 0});
        vecs.push_back('{5'b00110, 1, 0, 0, 1, 1, 1, 5'b11111, 0, 0, 1});
        vecs.push_back('{5'b00110, 1, 0, 0, 1, 1, 1, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b00110, 1, 0, 0, 1, 0, 0, 5'b00110, 0, 0, 0});
        vecs.push_back('{5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0});
        // second request edge while pending is absorbed
        vecs.push_back('{5'b00000, 0, 0, 0, 1, 0, 0, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b11000, 1, 0, 0, 1, 0, 0, 5'b11000, 0, 0, 0});
        vecs.push_back('{5'b01101, 1, 0, 0, 0, 1, 1, 5'b11001, 0, 0, 0});
        vecs.push_back('{5'b01101, 1, 0, 0, 0, 1, 0, 5'b11110, 0, 0, 0});
        vecs.push_back('{5'b01101, 1, 0, 0, 0, 1, 1, 5'b11111, 0, 0, 1});
        vecs.push_back('{5'b01101, 1, 0, 0, 0, 1, 1, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b01101, 1, 0, 0, 0, 0, 0, 5'b01101, 0, 0, 0});
        vecs.push_back('{5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0});
        vecs.push_back('{5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) runCycle(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset while CALL2 is pending
        runCycle('{5'b11000, 1, 0, 0, 0, 0, 0, 5'b11000, 0, 0, 0}, "midcall.enter");
        check("midcall.busyBefore", 32'(bus.busy), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("midcall.opCode", 32'(bus.opCode), 32'h0);
        check("midcall.busy", 32'(bus.busy), 32'h0);
        check("midcall.fetchHold", 32'(bus.fetchHold), 32'h1);
        @(posedge clk);
        #1;
        check("midcall.opCodeHeld", 32'(bus.opCode), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.fetchValid = 1'b0;
        mReset();

        pick[0] = 5'b11000; pick[1] = 5'b11010; pick[2] = 5'b11100; pick[3] = 5'b10001;
        pick[4] = 5'b11110; pick[5] = 5'b11111; pick[6] = 5'b11001; pick[7] = 5'b00000;
        irLevel = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            r.op = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : 5'($urandom_range(0, 31));
            r.v  = ($urandom_range(0, 4) != 0);
            r.st = ($urandom_range(0, 6) == 0);
            r.fl = ($urandom_range(0, 8) == 0);
            if ($urandom_range(0, 7) == 0) irLevel = !irLevel;
            r.ir    = irLevel;
            r.eHold = mHold(r.st, r.fl);
            r.eBusy = (owed.size() != 0);
            mStep(r.op, r.v, r.st, r.fl, r.ir, r.eOp, r.eBub, r.eImm, r.eAck);
            runCycle(r, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
